// File: rtl/keypad_pkg.sv
// Types, key codes and row-decode helpers shared by the keypad scanner and the
// code-compare logic.
package keypad_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    DEBOUNCE = 2'd1,
    HELD     = 2'd2,
    RELEASE  = 2'd3
  } kp_state_e;

  typedef enum logic [1:0] {
    NONE   = 2'd0,
    SINGLE = 2'd1,
    MULTI  = 2'd2
  } scan_kind_e;

  // Key code = {row_idx, col_idx}
  localparam logic [3:0] KEY_1    = 4'h0;
  localparam logic [3:0] KEY_2    = 4'h1;
  localparam logic [3:0] KEY_3    = 4'h2;
  localparam logic [3:0] KEY_A    = 4'h3;
  localparam logic [3:0] KEY_4    = 4'h4;
  localparam logic [3:0] KEY_5    = 4'h5;
  localparam logic [3:0] KEY_6    = 4'h6;
  localparam logic [3:0] KEY_B    = 4'h7;
  localparam logic [3:0] KEY_7    = 4'h8;
  localparam logic [3:0] KEY_8    = 4'h9;
  localparam logic [3:0] KEY_9    = 4'hA;
  localparam logic [3:0] KEY_C    = 4'hB;
  localparam logic [3:0] KEY_STAR = 4'hC;
  localparam logic [3:0] KEY_0    = 4'hD;
  localparam logic [3:0] KEY_HASH = 4'hE;
  localparam logic [3:0] KEY_D    = 4'hF;

  // Number of pressed (low) rows on the driven column.
  function automatic logic [2:0] row_press_count(input logic [3:0] row);
    logic [2:0] cnt;
    cnt = 3'd0;
    for (int i = 0; i < 4; i++) begin
      if (!row[i]) begin
        cnt = cnt + 3'd1;
      end else begin
        cnt = cnt;
      end
    end
    return cnt;
  endfunction

  // Index of the lowest pressed row; only meaningful when exactly one is low.
  function automatic logic [1:0] row_press_index(input logic [3:0] row);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!row[i]) begin
        idx = 2'(i);
      end else begin
        idx = idx;
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous keypad row lines; idles high
// (no key) out of reset.
module keypad_row_sync (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic [3:0] row_i,
  output logic [3:0] row_o
);

  logic [3:0] meta_q;
  logic [3:0] sync_q;

  // Two-stage capture of the row pins
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= 4'b1111;
      sync_q <= 4'b1111;
    end else begin
      meta_q <= row_i;
      sync_q <= meta_q;
    end
  end

  assign row_o = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column strobing, per-scan single/multi-key
// classification, debounced press/release FSM with a one-cycle key_valid pulse.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] keypad_row,
  output logic [3:0] keypad_col,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held
);

  localparam int DIV_W = $clog2(SCAN_DIV);
  localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_TGT  = CNT_W'(DEBOUNCE_SCANS);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [3:0]       row_sync_s;
  logic             run_q;
  logic [DIV_W-1:0] div_q, div_d;
  logic [1:0]       col_q, col_d;
  logic [3:0]       col_out_q;
  logic             sample_s;

  logic [2:0]       slot_cnt_s;
  logic [1:0]       slot_idx_s;
  logic [1:0]       base_cnt_s;
  logic [2:0]       sum_s;
  logic [1:0]       tot_s;
  logic [3:0]       code_s;
  scan_kind_e       kind_s;
  logic [1:0]       acc_cnt_q;
  logic [3:0]       acc_code_q;
  logic             res_valid_q;
  scan_kind_e       res_kind_q;
  logic [3:0]       res_code_q;

  kp_state_e        state_q, state_d;
  logic [3:0]       cand_q, cand_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc_s;
  logic [3:0]       key_code_q, key_code_d;
  logic             key_valid_q, key_valid_d;
  logic             key_held_q, key_held_d;

  keypad_row_sync u_row_sync (
    .clk_i  (clk),
    .rst_ni (reset),
    .row_i  (keypad_row),
    .row_o  (row_sync_s)
  );

  // Column slot divider; run_q holds the strobe idle for the first cycle out of reset
  always_comb begin
    div_d = div_q;
    col_d = col_q;
    if (run_q) begin
      if (div_q == DIV_LAST) begin
        div_d = '0;
        col_d = col_q + 2'd1;
      end else begin
        div_d = div_q + DIV_W'(1);
        col_d = col_q;
      end
    end else begin
      div_d = div_q;
      col_d = col_q;
    end
  end

  assign sample_s = run_q && (div_q == DIV_LAST);

  // Column counter and registered active-low strobe
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      run_q     <= 1'b0;
      div_q     <= '0;
      col_q     <= 2'd0;
      col_out_q <= 4'b1111;
    end else begin
      run_q     <= 1'b1;
      div_q     <= div_d;
      col_q     <= col_d;
      col_out_q <= ~(4'b0001 << col_d);
    end
  end

  assign slot_cnt_s = row_press_count(row_sync_s);
  assign slot_idx_s = row_press_index(row_sync_s);

  // Merge this slot's sample into the running scan; key count saturates at 2 (multi)
  always_comb begin
    base_cnt_s = (col_q == 2'd0) ? 2'd0 : acc_cnt_q;
    sum_s      = {1'b0, base_cnt_s} + slot_cnt_s;
    tot_s      = (sum_s >= 3'd2) ? 2'd2 : sum_s[1:0];
    code_s     = (base_cnt_s == 2'd1) ? acc_code_q : {slot_idx_s, col_q};
    case (tot_s)
      2'd0:    kind_s = NONE;
      2'd1:    kind_s = SINGLE;
      default: kind_s = MULTI;
    endcase
  end

  // Scan accumulator and the registered end-of-scan result
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_cnt_q   <= 2'd0;
      acc_code_q  <= 4'h0;
      res_valid_q <= 1'b0;
      res_kind_q  <= NONE;
      res_code_q  <= 4'h0;
    end else begin
      res_valid_q <= sample_s && (col_q == 2'd3);
      if (sample_s) begin
        acc_cnt_q  <= tot_s;
        acc_code_q <= code_s;
        res_kind_q <= kind_s;
        res_code_q <= code_s;
      end
    end
  end

  assign cnt_inc_s = (cnt_q == '1) ? cnt_q : cnt_q + CNT_ONE;

  // Debounce FSM next state; only scan-result cycles move it
  always_comb begin
    state_d     = state_q;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    key_code_d  = key_code_q;
    key_valid_d = 1'b0;
    if (res_valid_q) begin
      case (state_q)
        IDLE: begin
          if (res_kind_q == SINGLE) begin
            cand_d = res_code_q;
            if (CNT_TGT <= CNT_ONE) begin
              key_code_d  = res_code_q;
              key_valid_d = 1'b1;
              state_d     = HELD;
              cnt_d       = '0;
            end else begin
              state_d = DEBOUNCE;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = IDLE;
          end
        end
        DEBOUNCE: begin
          if (res_kind_q == SINGLE && res_code_q == cand_q) begin
            if (cnt_inc_s >= CNT_TGT) begin
              key_code_d  = cand_q;
              key_valid_d = 1'b1;
              state_d     = HELD;
              cnt_d       = '0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else if (res_kind_q == SINGLE) begin
            cand_d = res_code_q;
            cnt_d  = CNT_ONE;
          end else begin
            state_d = IDLE;
            cnt_d   = '0;
          end
        end
        HELD: begin
          if (res_kind_q == NONE) begin
            if (CNT_TGT <= CNT_ONE) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              state_d = RELEASE;
              cnt_d   = CNT_ONE;
            end
          end else begin
            state_d = HELD;
          end
        end
        RELEASE: begin
          if (res_kind_q == NONE) begin
            if (cnt_inc_s >= CNT_TGT) begin
              state_d = IDLE;
              cnt_d   = '0;
            end else begin
              cnt_d = cnt_inc_s;
            end
          end else begin
            state_d = HELD;
            cnt_d   = '0;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
    key_held_d = (state_d == HELD) || (state_d == RELEASE);
  end

  // FSM state and registered outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cand_q      <= 4'h0;
      cnt_q       <= '0;
      key_code_q  <= 4'h0;
      key_valid_q <= 1'b0;
      key_held_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cand_q      <= cand_d;
      cnt_q       <= cnt_d;
      key_code_q  <= key_code_d;
      key_valid_q <= key_valid_d;
      key_held_q  <= key_held_d;
    end
  end

  assign keypad_col = col_out_q;
  assign key_code   = key_code_q;
  assign key_valid  = key_valid_q;
  assign key_held   = key_held_q;

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: keypad matrix model, scan-aligned key stimulus and
// a per-scan press/release reference model.
module tb_keypad_scanner;
  import keypad_pkg::*;

  localparam int SD = 4;
  localparam int DS = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  keypad_row;
  logic [3:0]  keypad_col;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] pressed = 16'h0000;

  int cmp_cnt = 0;
  int err_cnt = 0;

  int         obs_np, obs_pc, obs_colbad;
  logic [3:0] obs_code;
  logic       obs_held;
  int         e_np;
  logic [3:0] e_code;
  logic       e_held;

  int         m_run, m_none, m_pend;
  logic [3:0] m_cand, m_code;
  logic       m_held;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS)) dut (
    .clk        (clk),
    .reset      (reset),
    .keypad_row (keypad_row),
    .keypad_col (keypad_col),
    .key_code   (key_code),
    .key_valid  (key_valid),
    .key_held   (key_held)
  );

  always #5 clk = ~clk;

  // Physical matrix: row r pulled low when its key on a low column is pressed
  always_comb begin
    keypad_row = 4'b1111;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (!keypad_col[c] && pressed[r*4+c]) keypad_row[r] = 1'b0;
  end

  function automatic logic [15:0] km(input logic [3:0] k);
    return 16'h0001 << k;
  endfunction

  task automatic model_clear();
    m_run = 0; m_none = 0; m_pend = 0; m_cand = 4'h0; m_code = 4'h0; m_held = 1'b0;
  endtask

  // One full scan with a stable key set: debounce runs of identical single keys,
  // releases on runs of empty scans.
  task automatic model_step(input logic [15:0] keys);
    int n, k;
    n = 0; k = 0;
    for (int i = 0; i < 16; i++) if (keys[i]) begin n++; k = i; end
    m_pend = 0;
    if (!m_held) begin
      if (n == 1) begin
        if (m_run > 0 && 4'(k) == m_cand) m_run++; else m_run = 1;
        m_cand = 4'(k);
        if (m_run >= DS) begin
          m_pend = 1; m_code = m_cand; m_held = 1'b1; m_run = 0; m_none = 0;
        end
      end else m_run = 0;
    end else begin
      if (n == 0) begin
        m_none++;
        if (m_none >= DS) begin m_held = 1'b0; m_none = 0; m_run = 0; end
      end else m_none = 0;
    end
  endtask

  // Drive one 16-cycle scan window and record what the DUT showed in it
  task automatic scan(input logic [15:0] keys);
    logic [3:0] ec;
    e_np = m_pend; e_code = m_code; e_held = m_held;
    obs_np = 0; obs_pc = -1; obs_colbad = 0;
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      if (i == 0) pressed = keys;
      ec = 4'b0001 << (i / SD);
      ec = ~ec;
      if (keypad_col !== ec) obs_colbad++;
      if (key_valid === 1'b1) begin obs_np++; obs_pc = i; end
    end
    obs_code = key_code;
    obs_held = key_held;
    model_step(keys);
  endtask

  task automatic do_reset();
    reset = 1'b0;
    model_clear();
    repeat (3) @(posedge clk);
    @(negedge clk) reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; pressed = 16'h0000; model_clear();
    repeat (2) @(posedge clk); #1;
    cmp_cnt++;
    if (keypad_col !== 4'b1111 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
      err_cnt++;
      $display("FAIL reset_outputs: got col=%b valid=%b held=%b code=%h want col=1111 valid=0 held=0 code=0",
               keypad_col, key_valid, key_held, key_code);
    end
    @(negedge clk) reset = 1'b1;
    for (int s = 0; s < 2; s++) begin
      scan(16'h0000);
      cmp_cnt++;
      if (obs_colbad != 0) begin
        err_cnt++; $display("FAIL reset_col_seq scan %0d: got %0d bad cycles want 0", s, obs_colbad);
      end
      cmp_cnt++;
      if (obs_np != 0 || obs_held !== 1'b0) begin
        err_cnt++; $display("FAIL reset_idle scan %0d: got pulses=%0d held=%b want 0/0", s, obs_np, obs_held);
      end
    end
  endtask

  task automatic test_hold8();
    int total;
    total = 0;
    for (int s = 0; s < 4; s++) begin
      scan(km(KEY_8));
      total += obs_np;
      cmp_cnt++;
      if (obs_np != e_np || obs_pc != ((e_np != 0) ? 1 : -1)) begin
        err_cnt++; $display("FAIL hold8_pulse scan %0d: got %0d@%0d want %0d", s, obs_np, obs_pc, e_np);
      end
      cmp_cnt++;
      if (obs_code !== e_code || obs_held !== e_held) begin
        err_cnt++; $display("FAIL hold8_state scan %0d: got code=%h held=%b want code=%h held=%b",
                            s, obs_code, obs_held, e_code, e_held);
      end
    end
    cmp_cnt++;
    if (total != 1 || obs_code !== 4'b1001 || obs_held !== 1'b1) begin
      err_cnt++; $display("FAIL hold8_result: got pulses=%0d code=%b held=%b want 1/1001/1", total, obs_code, obs_held);
    end
  endtask

  task automatic test_short_a();
    logic [15:0] stim [5];
    int total;
    stim = '{16'h0000, 16'h0000, km(KEY_A), 16'h0000, 16'h0000};
    total = 0;
    for (int s = 0; s < 5; s++) begin
      scan(stim[s]);
      if (s >= 2) total += obs_np;
      cmp_cnt++;
      if (obs_np != e_np || obs_code !== e_code || obs_held !== e_held) begin
        err_cnt++; $display("FAIL shortA scan %0d: got p=%0d code=%h held=%b want p=%0d code=%h held=%b",
                            s, obs_np, obs_code, obs_held, e_np, e_code, e_held);
      end
    end
    cmp_cnt++;
    if (total != 0 || obs_held !== 1'b0) begin
      err_cnt++; $display("FAIL shortA_result: got pulses=%0d held=%b want 0/0", total, obs_held);
    end
  endtask

  task automatic test_multi();
    logic [15:0] stim [8];
    int total;
    stim = '{km(KEY_A) | km(KEY_B), km(KEY_A) | km(KEY_B), km(KEY_A) | km(KEY_B),
             km(KEY_A) | km(KEY_B), 16'h0000, km(KEY_A), km(KEY_A), 16'h0000};
    total = 0;
    for (int s = 0; s < 8; s++) begin
      scan(stim[s]);
      total += obs_np;
      cmp_cnt++;
      if (obs_np != e_np || obs_pc != ((e_np != 0) ? 1 : -1) || obs_code !== e_code || obs_held !== e_held) begin
        err_cnt++; $display("FAIL multi scan %0d: got p=%0d@%0d code=%h held=%b want p=%0d code=%h held=%b",
                            s, obs_np, obs_pc, obs_code, obs_held, e_np, e_code, e_held);
      end
      if (s == 5) begin
        cmp_cnt++;
        if (total != 0) begin
          err_cnt++; $display("FAIL multi_no_pulse: got %0d pulses want 0", total);
        end
      end
    end
    cmp_cnt++;
    if (total != 1 || obs_code !== 4'b0011) begin
      err_cnt++; $display("FAIL multi_then_A: got pulses=%0d code=%b want 1/0011", total, obs_code);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] stim [13];
    int total;
    logic held10;
    stim = '{16'h0000, 16'h0000, km(KEY_B), km(KEY_B), km(KEY_B), 16'h0000, km(KEY_B),
             km(KEY_B), 16'h0000, 16'h0000, km(KEY_B), km(KEY_B), km(KEY_B)};
    total = 0; held10 = 1'bx;
    for (int s = 0; s < 13; s++) begin
      scan(stim[s]);
      total += obs_np;
      if (s == 10) held10 = obs_held;
      cmp_cnt++;
      if (obs_np != e_np || obs_pc != ((e_np != 0) ? 1 : -1) || obs_code !== e_code || obs_held !== e_held) begin
        err_cnt++; $display("FAIL rerelease scan %0d: got p=%0d@%0d code=%h held=%b want p=%0d code=%h held=%b",
                            s, obs_np, obs_pc, obs_code, obs_held, e_np, e_code, e_held);
      end
    end
    cmp_cnt++;
    if (total != 2 || obs_code !== 4'b0111 || obs_held !== 1'b1 || held10 !== 1'b0) begin
      err_cnt++; $display("FAIL rerelease_result: got pulses=%0d code=%b held=%b held10=%b want 2/0111/1/0",
                          total, obs_code, obs_held, held10);
    end
  endtask

  task automatic test_reset_mid_debounce();
    int total;
    scan(16'h0000);
    scan(16'h0000);
    scan(km(KEY_9));
    total = 0;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      if (key_valid === 1'b1) total++;
    end
    #2 reset = 1'b0;
    #1;
    cmp_cnt++;
    if (keypad_col !== 4'b1111 || key_valid !== 1'b0 || key_held !== 1'b0 || key_code !== 4'h0) begin
      err_cnt++;
      $display("FAIL async_reset: got col=%b valid=%b held=%b code=%h want 1111/0/0/0",
               keypad_col, key_valid, key_held, key_code);
    end
    do_reset();
    cmp_cnt++;
    if (total != 0 || key_valid !== 1'b0) begin
      err_cnt++; $display("FAIL reset_no_pulse: got %0d pulses valid=%b want 0/0", total, key_valid);
    end
    total = 0;
    for (int s = 0; s < 3; s++) begin
      scan((s < 2) ? km(KEY_9) : 16'h0000);
      total += obs_np;
      cmp_cnt++;
      if (obs_np != e_np || obs_pc != ((e_np != 0) ? 1 : -1) || obs_colbad != 0) begin
        err_cnt++; $display("FAIL after_reset scan %0d: got p=%0d@%0d colbad=%0d want p=%0d colbad=0",
                            s, obs_np, obs_pc, obs_colbad, e_np);
      end
    end
    cmp_cnt++;
    if (total != 1 || obs_code !== 4'b1010 || obs_held !== 1'b1) begin
      err_cnt++; $display("FAIL reset_then_9: got pulses=%0d code=%b held=%b want 1/1010/1", total, obs_code, obs_held);
    end
  endtask

  task automatic test_random();
    logic [15:0] m;
    int s, reps, kind, k1, k2;
    s = 0;
    while (s < 40) begin
      kind = $urandom_range(0, 3);
      reps = $urandom_range(1, 3);
      k1 = $urandom_range(0, 15);
      k2 = (k1 + 1 + $urandom_range(0, 14)) % 16;
      case (kind)
        0:       m = 16'h0000;
        3:       m = (16'h0001 << k1) | (16'h0001 << k2);
        default: m = 16'h0001 << k1;
      endcase
      for (int r = 0; r < reps; r++) begin
        scan(m);
        cmp_cnt++;
        if (obs_np != e_np || obs_pc != ((e_np != 0) ? 1 : -1) || obs_code !== e_code ||
            obs_held !== e_held || obs_colbad != 0) begin
          err_cnt++;
          $display("FAIL random scan %0d keys=%h: got p=%0d@%0d code=%h held=%b colbad=%0d want p=%0d code=%h held=%b",
                   s, m, obs_np, obs_pc, obs_code, obs_held, obs_colbad, e_np, e_code, e_held);
        end
        s++;
      end
    end
  endtask

  initial begin
    test_reset();
    test_hold8();
    test_short_a();
    test_multi();
    test_back_to_back();
    test_reset_mid_debounce();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
